// File: rtl/adc_osr_pkg.sv
// adc_osr_pkg: shared mode constants and width helpers for the oversampling unit.
package adc_osr_pkg;
  localparam logic OSR_MODE_AVG = 1'b1;
  localparam logic OSR_MODE_OVS = 1'b0;
  function automatic int acc_w(input int data_width, input int max_osr_log2);
    return data_width + max_osr_log2;
  endfunction
  function automatic int ch_w(input int channels);
    return channels > 1 ? $clog2(channels) : 1;
  endfunction
endpackage

// File: rtl/adc_osr_scaler.sv
// adc_osr_scaler: scales a frame sum by the average/oversample shift and saturates to OUT_WIDTH.
module adc_osr_scaler #(
  parameter int ACC_W = 19,
  parameter int OUT_WIDTH = 16
) (
  input  logic [ACC_W-1:0]     sum,
  input  logic [2:0]           osr,
  input  logic                 avg,
  output logic [OUT_WIDTH-1:0] result
);
  localparam int W = ACC_W > OUT_WIDTH ? ACC_W : OUT_WIDTH;
  logic [2:0] amt;
  logic [W-1:0] shifted;
  always_comb begin
    amt = avg ? osr : {1'b0, osr[2:1]};
    shifted = W'(sum) >> amt;
    result = |(shifted >> OUT_WIDTH) ? '1 : shifted[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/adc_osr_multichannel.sv
// adc_osr_multichannel: per-channel oversampling accumulators feeding a one-deep valid/ready result buffer.
module adc_osr_multichannel import adc_osr_pkg::*; #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int MAX_OSR_LOG2 = 7,
  localparam int CH_W = ch_w(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CH_W-1:0]       channel_in,
  input  logic [2:0]            osr_mode_in,
  input  logic                  avg_mode_in,
  input  logic                  clear_in,
  output logic [OUT_WIDTH-1:0]  result_out,
  output logic [CH_W-1:0]       result_channel_out,
  output logic                  result_valid_out,
  input  logic                  result_ready_in,
  output logic                  overrun_out,
  output logic                  chan_error_out
);
  localparam int ACC_W = acc_w(DATA_WIDTH, MAX_OSR_LOG2);
  localparam int CNT_W = MAX_OSR_LOG2 + 1;
  logic [ACC_W-1:0] acc [CHANNELS];
  logic [CNT_W-1:0] count [CHANNELS];
  logic [2:0] osr_q [CHANNELS];
  logic avg_q [CHANNELS];
  logic ch_ok, hit, first, avg_use, done, pop, load;
  logic [CH_W-1:0] sel;
  logic [2:0] osr_clamp, osr_use;
  logic [CNT_W-1:0] cnt_next;
  logic [ACC_W-1:0] sum;
  logic [OUT_WIDTH-1:0] scaled;
  // Mode comes from the ports on a channel's first sample, from its latch afterwards.
  always_comb begin
    ch_ok = int'(channel_in) < CHANNELS;
    sel = ch_ok ? channel_in : '0;
    hit = ena_in & ch_ok & ~clear_in;
    first = count[sel] == '0;
    osr_clamp = osr_mode_in > 3'(MAX_OSR_LOG2) ? 3'(MAX_OSR_LOG2) : osr_mode_in;
    osr_use = first ? osr_clamp : osr_q[sel];
    avg_use = first ? avg_mode_in : avg_q[sel];
    cnt_next = count[sel] + CNT_W'(1);
    sum = acc[sel] + ACC_W'(data_in);
    done = hit & (cnt_next == (CNT_W'(1) << osr_use));
    pop = result_valid_out & result_ready_in;
    load = done & (~result_valid_out | pop);
  end
  adc_osr_scaler #(.ACC_W(ACC_W), .OUT_WIDTH(OUT_WIDTH)) u_scaler (
    .sum(sum), .osr(osr_use), .avg(avg_use), .result(scaled)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        count[c] <= '0;
        osr_q[c] <= '0;
        avg_q[c] <= OSR_MODE_OVS;
      end
      result_out <= '0;
      result_channel_out <= '0;
      result_valid_out <= 1'b0;
      overrun_out <= 1'b0;
      chan_error_out <= 1'b0;
    end else if (clear_in) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        count[c] <= '0;
      end
      result_valid_out <= 1'b0;
      overrun_out <= 1'b0;
      chan_error_out <= 1'b0;
    end else begin
      chan_error_out <= ena_in & ~ch_ok;
      for (int c = 0; c < CHANNELS; c++) begin
        if (hit && sel == CH_W'(c)) begin
          acc[c] <= done ? '0 : sum;
          count[c] <= done ? '0 : cnt_next;
          if (first) begin
            osr_q[c] <= osr_clamp;
            avg_q[c] <= avg_mode_in;
          end
        end
      end
      if (load) begin
        result_out <= scaled;
        result_channel_out <= sel;
        result_valid_out <= 1'b1;
      end else if (pop) begin
        result_valid_out <= 1'b0;
      end
      if (done && !load) overrun_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_osr_multichannel.sv
// tb_adc_osr_multichannel: directed vectors against a 16-bit/4-channel and a 12-bit/5-channel instance.
module tb_adc_osr_multichannel;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;

  logic a_ena = 0, a_avg = 0, a_clear = 0, a_ready = 0;
  logic [11:0] a_data = 0;
  logic [1:0] a_ch = 0;
  logic [2:0] a_osr = 0;
  logic [15:0] a_result;
  logic [1:0] a_rch;
  logic a_valid, a_overrun, a_cerr;

  logic b_ena = 0, b_avg = 0, b_clear = 0, b_ready = 0;
  logic [11:0] b_data = 0;
  logic [2:0] b_ch = 0;
  logic [2:0] b_osr = 0;
  logic [11:0] b_result;
  logic [2:0] b_rch;
  logic b_valid, b_overrun, b_cerr;

  adc_osr_multichannel #(.DATA_WIDTH(12), .OUT_WIDTH(16), .CHANNELS(4), .MAX_OSR_LOG2(7)) dut_a (
    .clk(clk), .rst(rst), .ena_in(a_ena), .data_in(a_data), .channel_in(a_ch),
    .osr_mode_in(a_osr), .avg_mode_in(a_avg), .clear_in(a_clear),
    .result_out(a_result), .result_channel_out(a_rch), .result_valid_out(a_valid),
    .result_ready_in(a_ready), .overrun_out(a_overrun), .chan_error_out(a_cerr)
  );
  adc_osr_multichannel #(.DATA_WIDTH(12), .OUT_WIDTH(12), .CHANNELS(5), .MAX_OSR_LOG2(7)) dut_b (
    .clk(clk), .rst(rst), .ena_in(b_ena), .data_in(b_data), .channel_in(b_ch),
    .osr_mode_in(b_osr), .avg_mode_in(b_avg), .clear_in(b_clear),
    .result_out(b_result), .result_channel_out(b_rch), .result_valid_out(b_valid),
    .result_ready_in(b_ready), .overrun_out(b_overrun), .chan_error_out(b_cerr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One ena_in cycle on instance A; returns at the negedge after the capturing edge.
  task automatic sa(input logic [1:0] ch, input logic [11:0] d, input logic [2:0] osr, input logic avg);
    @(negedge clk);
    a_ena = 1; a_ch = ch; a_data = d; a_osr = osr; a_avg = avg;
    @(negedge clk);
    a_ena = 0;
  endtask

  task automatic sb(input logic [2:0] ch, input logic [11:0] d, input logic [2:0] osr, input logic avg);
    @(negedge clk);
    b_ena = 1; b_ch = ch; b_data = d; b_osr = osr; b_avg = avg;
    @(negedge clk);
    b_ena = 0;
  endtask

  task automatic pop_a();
    @(negedge clk);
    a_ready = 1;
    @(negedge clk);
    a_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("a_rst_result", a_result, 0);
    chk("a_rst_valid", a_valid, 0);
    chk("a_rst_overrun", a_overrun, 0);
    chk("a_rst_cerr", a_cerr, 0);
    chk("b_rst_valid", b_valid, 0);
    rst = 0;

    sa(0, 100, 2, 1); sa(0, 200, 2, 1); sa(0, 300, 2, 1);
    chk("avg_not_yet", a_valid, 0);
    sa(0, 400, 2, 1);
    chk("avg_valid", a_valid, 1);
    chk("avg_result", a_result, 250);
    chk("avg_ch", a_rch, 0);
    @(negedge clk);
    chk("avg_hold", a_result, 250);
    pop_a();
    chk("avg_popped", a_valid, 0);

    for (int i = 0; i < 16; i++) sa(1, 12'hFFF, 4, 0);
    chk("ovs_result", a_result, 16'h3FFC);
    chk("ovs_ch", a_rch, 1);
    pop_a();

    sa(2, 10, 1, 1); sa(3, 50, 1, 1); sa(2, 30, 1, 1);
    chk("ilv_ch2_valid", a_valid, 1);
    sa(3, 70, 1, 1);
    chk("ilv_overrun", a_overrun, 1);
    chk("ilv_result_intact", a_result, 20);
    chk("ilv_ch_intact", a_rch, 2);
    pop_a();
    chk("ilv_overrun_sticky", a_overrun, 1);
    chk("ilv_no_ch3", a_valid, 0);

    sa(0, 4, 2, 1); sa(0, 8, 2, 1); sa(0, 12, 0, 1);
    chk("midosr_3rd", a_valid, 0);
    sa(0, 16, 0, 1);
    chk("midosr_result", a_result, 10);
    pop_a();
    sa(0, 7, 0, 1);
    chk("osr0_valid", a_valid, 1);
    chk("osr0_result", a_result, 7);
    pop_a();

    sa(0, 100, 1, 1);
    sa(1, 5, 0, 1);
    chk("pre_clear_valid", a_valid, 1);
    @(negedge clk);
    a_clear = 1; a_ena = 1; a_ch = 0; a_data = 999; a_osr = 1; a_avg = 1;
    @(negedge clk);
    a_clear = 0; a_ena = 0;
    chk("clear_valid", a_valid, 0);
    chk("clear_overrun", a_overrun, 0);
    sa(0, 2, 1, 1);
    chk("clear_flushed", a_valid, 0);
    sa(0, 4, 1, 1);
    chk("clear_result", a_result, 3);
    pop_a();

    sa(1, 9, 0, 1);
    a_ready = 1;
    sa(2, 11, 0, 1);
    a_ready = 0;
    chk("popload_valid", a_valid, 1);
    chk("popload_result", a_result, 11);
    chk("popload_ch", a_rch, 2);
    chk("popload_overrun", a_overrun, 0);

    sa(0, 1000, 2, 1); sa(0, 1000, 2, 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_result", a_result, 0);
    chk("arst_ch", a_rch, 0);
    @(negedge clk);
    rst = 0;
    sa(0, 40, 2, 1); sa(0, 80, 2, 1); sa(0, 120, 2, 1);
    chk("arst_partial", a_valid, 0);
    sa(0, 160, 2, 1);
    chk("arst_clean", a_result, 100);

    for (int i = 0; i < 4; i++) sb(0, 12'hFFF, 2, 0);
    chk("sat_result", b_result, 12'hFFF);
    @(negedge clk); b_ready = 1; @(negedge clk); b_ready = 0;
    sb(5, 123, 0, 1);
    chk("cerr_pulse", b_cerr, 1);
    chk("cerr_no_result", b_valid, 0);
    @(negedge clk);
    chk("cerr_clears", b_cerr, 0);
    sb(4, 321, 0, 1);
    chk("lastch_result", b_result, 321);
    chk("lastch_ch", b_rch, 4);
    chk("lastch_cerr", b_cerr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
